// File: rtl/yrv_board_pkg.sv
// Board-level constants shared by the key conditioner and the board top (timer limits).
package yrv_board_pkg;

  localparam int CLK_HZ_DEFAULT = 50000000;

  // Number of clk cycles spanning ms milliseconds.
  function automatic int db_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/yrv_key_conditioner_debounce.sv
// One key channel: 2-flop synchroniser, saturating stability counter, debounced level
// and single-cycle rise/fall indications aligned with the key_state update edge.
module key_debounce_ch #(
  parameter int DB_CYCLES      = 8,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic resetb,
  input  logic key_raw,
  output logic key_state,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic              REL_LVL = KEY_ACTIVE_LOW;

  logic             sync_p0;
  logic             sync_p1;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // Stage p0/p1: synchroniser, reset to the released raw level so reset release is silent
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_p0 <= REL_LVL;
      sync_p1 <= REL_LVL;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign s      = sync_p1 ^ KEY_ACTIVE_LOW;
  assign settle = (s != key_state) && (cnt == CNT_MAX);

  // Stability stage: counter only advances while s disagrees, so it stops at CNT_MAX
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt       <= '0;
      key_state <= 1'b0;
    end else if (s == key_state) begin
      cnt <= '0;
    end else if (settle) begin
      cnt       <= '0;
      key_state <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise = settle & s;
  assign fall = settle & ~s;

endmodule

// File: rtl/yrv_key_conditioner.sv
// Push-button input stage: per-key debounce, sticky press/release events and a
// registered level interrupt request for the MCU external interrupt.
module yrv_key_conditioner
  import yrv_board_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int CLK_HZ         = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_MS    = 10,
  parameter int DB_CYCLES      = db_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] evt_clr,
  input  logic [N_KEYS-1:0] irq_en,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_evt,
  output logic [N_KEYS-1:0] release_evt,
  output logic              ei_req
);

  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES      (DB_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .resetb    (resetb),
      .key_raw   (key_raw[i]),
      .key_state (key_state[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  // Event stage: a set on the clear edge wins so no transition is ever lost
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      press_evt   <= '0;
      release_evt <= '0;
    end else begin
      press_evt   <= (press_evt & ~evt_clr) | rise;
      release_evt <= (release_evt & ~evt_clr) | fall;
    end
  end

  // Interrupt stage: one cycle behind the sticky bits
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ei_req <= 1'b0;
    end else begin
      ei_req <= |(irq_en & (press_evt | release_evt));
    end
  end

endmodule

// File: tb/tb_yrv_key_conditioner.sv
// Bench for yrv_key_conditioner: constant vector table, directed corner sequences and
// randomized stimulus, all checked against a window-based behavioural model.
module tb_yrv_key_conditioner;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       resetb;
  logic [3:0] key_raw, evt_clr, irq_en;
  logic [3:0] key_state, press_evt, release_evt;
  logic       ei_req;

  int errors = 0;
  int checks = 0;

  yrv_key_conditioner #(
    .N_KEYS(4), .DB_CYCLES(DB), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .resetb(resetb), .key_raw(key_raw), .evt_clr(evt_clr), .irq_en(irq_en),
    .key_state(key_state), .press_evt(press_evt), .release_evt(release_evt), .ei_req(ei_req)
  );

  always #5 clk = ~clk;

  // Model state: raw samples delayed two edges, and the last DB pressed-level vectors.
  logic [3:0] raw_q[$];
  logic [3:0] s_win[$];
  logic [3:0] m_state, m_press, m_rel;
  logic       m_ei;

  typedef struct {
    logic [3:0] raw, clr, en;
    int         n;
    logic [3:0] st, pr, rl;
    logic       ei;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = '0; m_press = '0; m_rel = '0; m_ei = 1'b0;
    raw_q.delete(); s_win.delete();
    raw_q.push_back(4'hF); raw_q.push_back(4'hF);
  endtask

  // A key flips once the last DB synchronised samples all disagree with its level.
  task automatic model_edge(input logic [3:0] raw, input logic [3:0] clr, input logic [3:0] en);
    logic [3:0] s, rise, fall;
    logic       ei_n, flip;
    ei_n = |(en & (m_press | m_rel));
    s = ~raw_q[0];
    void'(raw_q.pop_front());
    raw_q.push_back(raw);
    s_win.push_back(s);
    if (s_win.size() > DB) void'(s_win.pop_front());
    rise = '0; fall = '0;
    for (int i = 0; i < 4; i++) begin
      if (s_win.size() == DB) begin
        flip = 1'b1;
        foreach (s_win[j]) if (s_win[j][i] == m_state[i]) flip = 1'b0;
        if (flip) begin
          if (m_state[i]) fall[i] = 1'b1; else rise[i] = 1'b1;
          m_state[i] = ~m_state[i];
        end
      end
    end
    m_press = (m_press & ~clr) | rise;
    m_rel   = (m_rel & ~clr) | fall;
    m_ei    = ei_n;
  endtask

  task automatic check_model();
    check("model_key_state", key_state, m_state);
    check("model_press_evt", press_evt, m_press);
    check("model_release_evt", release_evt, m_rel);
    check("model_ei_req", {3'b0, ei_req}, {3'b0, m_ei});
  endtask

  task automatic step(input int n = 1);
    logic [3:0] raw_s, clr_s, en_s;
    logic       rb;
    for (int k = 0; k < n; k++) begin
      raw_s = key_raw; clr_s = evt_clr; en_s = irq_en; rb = resetb;
      @(posedge clk);
      if (!rb) model_reset(); else model_edge(raw_s, clr_s, en_s);
      #1;
      check_model();
    end
  endtask

  initial begin
    resetb = 1'b0; key_raw = 4'hF; evt_clr = '0; irq_en = '0;
    model_reset();
    #1;
    check("reset_state", key_state, 4'h0);
    check("reset_evt", press_evt | release_evt, 4'h0);
    step(3);
    resetb = 1'b1;

    // Reset hold, clean press on key 0 with interrupt, then release and clear.
    tbl[0] = '{4'hF, 4'h0, 4'h0, 20, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{4'hE, 4'h0, 4'h1,  9, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{4'hE, 4'h0, 4'h1,  1, 4'h1, 4'h1, 4'h0, 1'b0};
    tbl[3] = '{4'hE, 4'h0, 4'h1,  1, 4'h1, 4'h1, 4'h0, 1'b1};
    tbl[4] = '{4'hF, 4'h0, 4'h1,  9, 4'h1, 4'h1, 4'h0, 1'b1};
    tbl[5] = '{4'hF, 4'h0, 4'h1,  1, 4'h0, 4'h1, 4'h1, 1'b1};
    tbl[6] = '{4'hF, 4'h1, 4'h1,  1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[7] = '{4'hF, 4'h0, 4'h1,  1, 4'h0, 4'h0, 4'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      key_raw = tbl[i].raw; evt_clr = tbl[i].clr; irq_en = tbl[i].en;
      step(tbl[i].n);
      check($sformatf("tbl%0d_key_state", i), key_state, tbl[i].st);
      check($sformatf("tbl%0d_press_evt", i), press_evt, tbl[i].pr);
      check($sformatf("tbl%0d_release_evt", i), release_evt, tbl[i].rl);
      check($sformatf("tbl%0d_ei_req", i), {3'b0, ei_req}, {3'b0, tbl[i].ei});
    end
    irq_en = '0;

    // Bounce on key 1, then a clean press must still take the full latency.
    for (int i = 0; i < 10; i++) begin
      key_raw[1] = ~key_raw[1];
      step(3);
    end
    step(12);
    check("bounce_state", key_state, 4'h0);
    check("bounce_evt", press_evt | release_evt, 4'h0);
    key_raw[1] = 1'b0;
    step(9);
    check("post_bounce_early", key_state, 4'h0);
    step(1);
    check("post_bounce_press", key_state, 4'h2);
    key_raw[1] = 1'b1;
    step(10);
    evt_clr = 4'hF; step(1); evt_clr = '0;

    // Clear colliding with set on key 2.
    irq_en = 4'h4;
    key_raw[2] = 1'b0;
    step(9);
    evt_clr = 4'h4;
    step(1);
    check("collide_press_kept", press_evt, 4'h4);
    evt_clr = '0;
    step(1);
    check("collide_ei_rise", {3'b0, ei_req}, 4'h1);
    evt_clr = 4'h4;
    step(1);
    check("second_clr_press", press_evt, 4'h0);
    check("second_clr_ei_hold", {3'b0, ei_req}, 4'h1);
    evt_clr = '0;
    step(1);
    check("second_clr_ei_fall", {3'b0, ei_req}, 4'h0);
    key_raw[2] = 1'b1;
    step(10);
    evt_clr = 4'hF; step(1); evt_clr = '0;
    irq_en = '0;
    step(2);

    // Masked press and release on key 3.
    key_raw[3] = 1'b0; step(10);
    key_raw[3] = 1'b1; step(10);
    check("masked_press", press_evt, 4'h8);
    check("masked_release", release_evt, 4'h8);
    step(2);
    check("masked_ei", {3'b0, ei_req}, 4'h0);
    irq_en = 4'h8;
    step(1);
    check("unmask_ei", {3'b0, ei_req}, 4'h1);
    evt_clr = 4'hF; irq_en = '0; step(1); evt_clr = '0;
    step(2);

    // Reset mid-debounce with key 0 held through it.
    key_raw = 4'hE;
    step(5);
    resetb = 1'b0;
    model_reset();
    #1;
    check("midrst_state", key_state, 4'h0);
    step(2);
    resetb = 1'b1;
    step(9);
    check("midrst_early", key_state, 4'h0);
    step(1);
    check("midrst_state_rise", key_state, 4'h1);
    check("midrst_press", press_evt, 4'h1);
    key_raw = 4'hF;
    step(12);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 80; seg++) begin
      int hold;
      key_raw = key_raw ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) irq_en = 4'($urandom_range(0, 15));
      hold = (seg % 3 == 0) ? $urandom_range(9, 20) : $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        evt_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        step(1);
      end
    end
    evt_clr = '0;
    step(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
